// File: rtl/doorlock_ctrl.sv
// Keypad door lock: buffers four one-hot decoded digits, checks them against a
// stored password, times the door release and locks out after repeated failures.
module doorlock_ctrl #(
  parameter int UNLOCK_CYCLES  = 50000000,
  parameter int LOCKOUT_CYCLES = 500000000,
  parameter int MAX_FAIL       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] dig,
  input  logic       key_vld,
  input  logic       key_ent,
  input  logic       key_clr,
  output logic       unlock,
  output logic       lockout,
  output logic       err,
  output logic       pw_set,
  output logic [2:0] digit_cnt,
  output logic [1:0] o_dbg_state
);
  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] UNL_LOAD = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LCK_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0]    FAIL_LIM = 2'(MAX_FAIL);

  typedef enum logic [1:0] {ST_ENTRY, ST_CHECK, ST_OPEN, ST_LOCKOUT} state_t;

  state_t          r_state, w_nxt;
  logic [15:0]     r_buf, w_buf, r_pw, w_pw;
  logic [2:0]      r_cnt, w_cnt;
  logic            r_ovf, w_ovf;
  logic [1:0]      r_fail, w_fail;
  logic [TW-1:0]   r_tmr, w_tmr;
  logic            r_unlock, r_lockout, r_err, r_pwset;
  logic            w_err, w_pwset, w_take, w_onehot, w_match;
  logic [3:0]      w_idx;

  always_comb begin
    w_idx = 4'd0;
    for (int k = 0; k < 10; k++)
      if (dig[k]) w_idx = 4'(k);
  end

  assign w_onehot = $onehot(dig);
  assign w_match  = (r_cnt == 3'd4) && !r_ovf && (r_buf == r_pw);

  always_comb begin
    w_nxt   = r_state;
    w_buf   = r_buf;
    w_pw    = r_pw;
    w_cnt   = r_cnt;
    w_ovf   = r_ovf;
    w_fail  = r_fail;
    w_tmr   = r_tmr;
    w_err   = 1'b0;
    w_pwset = 1'b0;
    w_take  = 1'b0;
    case (r_state)
      ST_ENTRY: begin
        if (key_clr) begin
          w_cnt = 3'd0;
          w_ovf = 1'b0;
        end else if (key_ent) begin
          w_nxt = ST_CHECK;
        end else if (key_vld) begin
          w_take = 1'b1;
        end
      end
      ST_CHECK: begin
        w_buf = 16'h0;
        w_cnt = 3'd0;
        w_ovf = 1'b0;
        if (w_match) begin
          w_nxt  = ST_OPEN;
          w_fail = 2'd0;
          w_tmr  = UNL_LOAD;
        end else begin
          w_err  = 1'b1;
          w_fail = (r_fail == 2'd3) ? 2'd3 : r_fail + 2'd1;
          if (w_fail == FAIL_LIM) begin
            w_nxt = ST_LOCKOUT;
            w_tmr = LCK_LOAD;
          end else begin
            w_nxt = ST_ENTRY;
          end
        end
      end
      ST_OPEN: begin
        if (r_tmr != '0) w_tmr = r_tmr - 1'b1;
        if (key_clr) begin
          w_nxt = ST_ENTRY;
          w_buf = 16'h0;
          w_cnt = 3'd0;
          w_ovf = 1'b0;
        end else if (key_ent) begin
          if (r_cnt == 3'd4 && !r_ovf) begin
            w_pw    = r_buf;
            w_pwset = 1'b1;
            w_nxt   = ST_ENTRY;
            w_buf   = 16'h0;
            w_cnt   = 3'd0;
          end else begin
            w_err = 1'b1;
          end
        end else if (key_vld) begin
          w_take = 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (r_tmr != '0) begin
          w_tmr = r_tmr - 1'b1;
        end else begin
          w_nxt  = ST_ENTRY;
          w_fail = 2'd0;
        end
      end
      default: w_nxt = ST_ENTRY;
    endcase

    // First digit lands in the top nibble so the buffer reads like the password.
    if (w_take) begin
      if (!w_onehot) begin
        w_err = 1'b1;
      end else if (r_cnt == 3'd4) begin
        w_ovf = 1'b1;
      end else begin
        case (r_cnt[1:0])
          2'd0:    w_buf[15:12] = w_idx;
          2'd1:    w_buf[11:8]  = w_idx;
          2'd2:    w_buf[7:4]   = w_idx;
          default: w_buf[3:0]   = w_idx;
        endcase
        w_cnt = r_cnt + 3'd1;
      end
    end

    if (r_state == ST_OPEN && w_nxt == ST_OPEN && r_tmr == '0) begin
      w_nxt = ST_ENTRY;
      w_buf = 16'h0;
      w_cnt = 3'd0;
      w_ovf = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_ENTRY;
      r_buf     <= 16'h0;
      r_pw      <= 16'h1234;
      r_cnt     <= 3'd0;
      r_ovf     <= 1'b0;
      r_fail    <= 2'd0;
      r_tmr     <= '0;
      r_unlock  <= 1'b0;
      r_lockout <= 1'b0;
      r_err     <= 1'b0;
      r_pwset   <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_buf     <= w_buf;
      r_pw      <= w_pw;
      r_cnt     <= w_cnt;
      r_ovf     <= w_ovf;
      r_fail    <= w_fail;
      r_tmr     <= w_tmr;
      r_unlock  <= (w_nxt == ST_OPEN);
      r_lockout <= (w_nxt == ST_LOCKOUT);
      r_err     <= w_err;
      r_pwset   <= w_pwset;
    end
  end

  assign unlock      = r_unlock;
  assign lockout     = r_lockout;
  assign err         = r_err;
  assign pw_set      = r_pwset;
  assign digit_cnt   = r_cnt;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_doorlock_ctrl.sv
// Bench for doorlock_ctrl: directed scenarios plus random key traffic, every
// cycle compared against a digit-queue model of the lock.
module tb_doorlock_ctrl;
  localparam int UNL = 8;
  localparam int LCK = 16;
  localparam int MAXF = 3;
  localparam int M_ENTRY = 0, M_CHECK = 1, M_OPEN = 2, M_LOCK = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] dig = '0;
  logic       key_vld = 1'b0, key_ent = 1'b0, key_clr = 1'b0;
  logic       unlock, lockout, err, pw_set;
  logic [2:0] digit_cnt;
  logic [1:0] dbg_state;

  int n_total = 0;
  int n_bad   = 0;

  // model state
  int m_mode, m_fails, m_open_n, m_lock_n;
  int m_buf[$];
  int m_pw[4];
  bit m_ovf, m_err, m_pws;

  doorlock_ctrl #(.UNLOCK_CYCLES(UNL), .LOCKOUT_CYCLES(LCK), .MAX_FAIL(MAXF)) dut (
    .clk(clk), .rst(rst), .dig(dig), .key_vld(key_vld), .key_ent(key_ent),
    .key_clr(key_clr), .unlock(unlock), .lockout(lockout), .err(err),
    .pw_set(pw_set), .digit_cnt(digit_cnt), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_mode = M_ENTRY; m_fails = 0; m_open_n = 0; m_lock_n = 0;
    m_buf.delete(); m_ovf = 0; m_err = 0; m_pws = 0;
    m_pw[0] = 1; m_pw[1] = 2; m_pw[2] = 3; m_pw[3] = 4;
  endtask

  task automatic m_clear();
    m_buf.delete();
    m_ovf = 0;
  endtask

  task automatic m_add(input logic [9:0] d);
    if ($countones(d) != 1) m_err = 1;
    else if (m_buf.size() == 4) m_ovf = 1;
    else for (int k = 0; k < 10; k++) if (d[k]) m_buf.push_back(k);
  endtask

  task automatic m_step(input logic [9:0] d, input logic v, input logic e, input logic c);
    bit ok;
    m_err = 0;
    m_pws = 0;
    case (m_mode)
      M_ENTRY: begin
        if (c) m_clear();
        else if (e) m_mode = M_CHECK;
        else if (v) m_add(d);
      end
      M_CHECK: begin
        ok = (m_buf.size() == 4) && !m_ovf;
        if (ok) for (int i = 0; i < 4; i++) if (m_buf[i] != m_pw[i]) ok = 0;
        m_clear();
        if (ok) begin
          m_mode = M_OPEN; m_fails = 0; m_open_n = 0;
        end else begin
          m_err = 1;
          if (m_fails < 3) m_fails++;
          if (m_fails == MAXF) begin m_mode = M_LOCK; m_lock_n = 0; end
          else m_mode = M_ENTRY;
        end
      end
      M_OPEN: begin
        m_open_n++;
        if (c) begin
          m_clear(); m_mode = M_ENTRY;
        end else if (e) begin
          if (m_buf.size() == 4 && !m_ovf) begin
            for (int i = 0; i < 4; i++) m_pw[i] = m_buf[i];
            m_pws = 1; m_clear(); m_mode = M_ENTRY;
          end else m_err = 1;
        end else if (v) m_add(d);
        if (m_mode == M_OPEN && m_open_n == UNL) begin
          m_mode = M_ENTRY; m_clear();
        end
      end
      default: begin
        m_lock_n++;
        if (m_lock_n == LCK) begin m_mode = M_ENTRY; m_fails = 0; end
      end
    endcase
  endtask

  task automatic cmp_outs();
    check("unlock", unlock, (m_mode == M_OPEN));
    check("lockout", lockout, (m_mode == M_LOCK));
    check("err", err, m_err);
    check("pw_set", pw_set, m_pws);
    check("digit_cnt", digit_cnt, m_buf.size());
  endtask

  // Drive one cycle of keys, advance model at the edge, compare on the falling edge.
  task automatic cyc(input logic [9:0] d, input logic v, input logic e, input logic c);
    dig = d; key_vld = v; key_ent = e; key_clr = c;
    @(posedge clk);
    m_step(d, v, e, c);
    @(negedge clk);
    dig = '0; key_vld = 0; key_ent = 0; key_clr = 0;
    cmp_outs();
  endtask

  task automatic press(input int k);
    logic [9:0] d;
    d = '0;
    d[k] = 1'b1;
    cyc(d, 1, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, 0, 0, 0);
  endtask

  task automatic code(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
  endtask

  initial begin
    int n;
    logic [9:0] d;
    int r;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_unlock", unlock, 0);
    check("rst_digit_cnt", digit_cnt, 0);
    check("rst_err", err, 0);
    rst = 0;

    // correct code: unlock stays high for exactly UNL cycles
    code(1, 2, 3, 4);
    cyc('0, 0, 1, 0);
    check("check_state", dbg_state, 2'd1);
    n = 0;
    for (int i = 0; i < 12; i++) begin idle(1); if (unlock) n++; end
    check("open_len", n, UNL);
    check("after_open_cnt", digit_cnt, 0);

    // three wrong entries then lockout, keys ignored
    for (int t = 0; t < 3; t++) begin
      code(9, 9, 9, 9);
      cyc('0, 0, 1, 0);
      if (t < 2) idle(1);
    end
    n = 0;
    for (int i = 0; i < 21; i++) begin
      if (i >= 1 && i <= 12) cyc(10'(i % 2 == 0 ? 10'h003 : 10'h020), 1, i % 5 == 0, i % 7 == 0);
      else idle(1);
      if (lockout) n++;
    end
    check("lock_len", n, LCK);
    code(1, 2, 3, 4);
    cyc('0, 0, 1, 0);
    idle(2);
    check("unlock_after_lock", unlock, 1);

    // change password while open
    code(5, 6, 7, 8);
    cyc('0, 0, 1, 0);
    idle(1);
    code(1, 2, 3, 4);
    cyc('0, 0, 1, 0);
    idle(2);
    code(5, 6, 7, 8);
    cyc('0, 0, 1, 0);
    idle(2);
    check("new_pw_open", unlock, 1);
    idle(UNL);

    // overflow and a bad two-hot key
    code(1, 2, 3, 4);
    press(5);
    cyc('0, 0, 1, 0);
    idle(1);
    press(3);
    cyc(10'b0000000011, 1, 0, 0);
    check("bad_key_cnt", digit_cnt, 1);
    cyc('0, 0, 0, 1);

    // clear wins over enter and digit
    press(1); press(2); press(3);
    cyc(10'h002, 1, 1, 1);
    check("clr_prio_cnt", digit_cnt, 0);
    idle(1);

    // reset mid-OPEN drops unlock at once and restores 1234
    code(5, 6, 7, 8);
    cyc('0, 0, 1, 0);
    idle(3);
    #2 rst = 1;
    #1;
    check("rst_mid_open", unlock, 0);
    m_reset();
    @(negedge clk);
    rst = 0;
    code(1, 2, 3, 4);
    cyc('0, 0, 1, 0);
    idle(2);
    check("pw_restored", unlock, 1);
    idle(UNL);

    // random traffic
    for (int i = 0; i < 900; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        code(m_pw[0], m_pw[1], m_pw[2], m_pw[3]);
        cyc('0, 0, 1, 0);
      end else begin
        if ($urandom_range(0, 9) == 0) d = 10'($urandom_range(0, 1023));
        else begin d = '0; d[$urandom_range(0, 9)] = 1'b1; end
        cyc(d, r < 50, r >= 50 && r < 57, r >= 57 && r < 60);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/doorlock_ctrl.md
DOORLOCK_CTRL -- requirements
Module: doorlock_ctrl

Interface
REQ-001 SHALL have parameter UNLOCK_CYCLES, default 50000000, the number of cycles unlock stays high.
REQ-002 SHALL have parameter LOCKOUT_CYCLES, default 500000000, the number of cycles keys are ignored after 3 failures.
REQ-003 SHALL have parameter MAX_FAIL, default 3, the consecutive failures that trigger lockout.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-006 SHALL have port dig, input, 10 bits, the one-hot decoded digit from the BCD decoder stage (dig[k]=1 means digit k).
REQ-007 SHALL have port key_vld, input, 1 bit, a one-cycle strobe qualifying dig.
REQ-008 SHALL have port key_ent, input, 1 bit, a one-cycle "enter" strobe.
REQ-009 SHALL have port key_clr, input, 1 bit, a one-cycle "clear/relock" strobe.
REQ-010 SHALL have port unlock, output, 1 bit, the door release, high in OPEN.
REQ-011 SHALL have port lockout, output, 1 bit, high in LOCKOUT.
REQ-012 SHALL have port err, output, 1 bit, a one-cycle pulse on a wrong code or bad key.
REQ-013 SHALL have port pw_set, output, 1 bit, a one-cycle pulse when a new password is stored.
REQ-014 SHALL have port digit_cnt, output, 3 bits, the digits currently buffered (0..4).

Function
REQ-015 SHALL implement states ENTRY, CHECK, OPEN, LOCKOUT as registered FSM.
REQ-016 SHALL treat dig as valid only when exactly one bit set; key_vld with zero or multiple bits set SHALL be dropped and pulse err next cycle.
REQ-017 SHALL apply per-cycle priority key_clr > key_ent > key_vld; lower-priority strobes in the same cycle are discarded.
REQ-018 SHALL, in ENTRY/OPEN, store a valid digit (4-bit index) at buffer[digit_cnt] and increment digit_cnt, saturating at 4; a 5th+ digit SHALL set an overflow flag instead.
REQ-019 SHALL, on key_clr in ENTRY, clear digit_cnt and overflow; fail count unchanged.
REQ-020 SHALL, on key_ent in ENTRY, go to CHECK next edge; CHECK lasts exactly 1 cycle.
REQ-021 SHALL declare match in CHECK iff digit_cnt==4, overflow==0, and buffer equals the stored 16-bit password.
REQ-022 SHALL on match go to OPEN, clear fail count, clear buffer/digit_cnt.
REQ-023 SHALL on mismatch pulse err, increment fail count (2-bit saturating), clear buffer; if new count==MAX_FAIL go to LOCKOUT else ENTRY.
REQ-024 SHALL hold unlock=1 for exactly UNLOCK_CYCLES cycles in OPEN, then return to ENTRY.
REQ-025 SHALL, in OPEN, on key_ent with digit_cnt==4 and no overflow, write buffer to password, pulse pw_set, go to ENTRY; key_ent otherwise pulses err and stays in OPEN with timer running.
REQ-026 SHALL, on key_clr in OPEN, drop unlock next cycle and go to ENTRY.
REQ-027 SHALL ignore all keys in LOCKOUT (no err), count LOCKOUT_CYCLES cycles, then clear fail count and enter ENTRY.
REQ-028 SHALL size timers to ceil(log2(max(UNLOCK_CYCLES,LOCKOUT_CYCLES)+1)) bits, reloaded on state entry, no wrap.
REQ-029 SHALL drive all outputs from registers.

Reset
REQ-030 SHALL on rst: state=ENTRY, unlock=0, lockout=0, err=0, pw_set=0, digit_cnt=0, overflow=0, fail count=0, timers=0.
REQ-031 SHALL reset password to digits 1,2,3,4 (16'h1234) only by rst; rst mid-OPEN or mid-LOCKOUT drops outputs asynchronously.

Verification (UNLOCK_CYCLES=8, LOCKOUT_CYCLES=16)
REQ-032 SHALL check: digits 1,2,3,4 then key_ent -> CHECK 1 cycle, unlock high exactly 8 cycles, then ENTRY, digit_cnt=0.
REQ-033 SHALL check: three entries 9,9,9,9 + key_ent -> err pulse each; lockout=1 after 3rd for 16 cycles; keys during lockout produce no err; after, 1,2,3,4 unlocks.
REQ-034 SHALL check: in OPEN enter 5,6,7,8 + key_ent -> pw_set pulse; then 1,2,3,4 fails (err), 5,6,7,8 unlocks.
REQ-035 SHALL check: 1,2,3,4,5 + key_ent -> err (overflow); dig=10'b0000000011 with key_vld -> err, digit_cnt unchanged.
REQ-036 SHALL check: key_clr+key_ent+key_vld same cycle after 3 digits -> digit_cnt=0, no CHECK; rst asserted mid-OPEN -> unlock=0 immediately, password back to 1234.
